axis_arbiter: RTL and testbench
===============================

AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 32, is the beat width in bits (multiple of 8).
REQ-002 Parameter SEL_WIDTH, default 2, is the width of the grant index.
REQ-003 Parameter INTF_NUM, default 4, is the number of input streams (INTF_NUM <= 2**SEL_WIDTH).
REQ-004 axis_aclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 axis_reset  in  1  asynchronous, active-high reset.
REQ-006 s_axis_sel_tdata  in  INTF_NUM*AXIS_DATA_WIDTH  input data; stream i at slice [i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH].
REQ-007 s_axis_sel_tkeep  in  INTF_NUM*AXIS_DATA_WIDTH/8  byte enables, same slicing.
REQ-008 s_axis_sel_tvalid / s_axis_sel_tlast  in  INTF_NUM each  per-stream valid and last.
REQ-009 s_axis_sel_tready  out  INTF_NUM  per-stream ready.
REQ-010 m_axis_tdata / m_axis_tkeep / m_axis_tvalid / m_axis_tlast  out  AXIS_DATA_WIDTH / AXIS_DATA_WIDTH/8 / 1 / 1  merged output stream.
REQ-011 m_axis_tready  in  1  downstream ready.
REQ-012 grant_sel  out  SEL_WIDTH  index of the stream currently owning the output; drives a downstream selector sel for return traffic.
REQ-013 grant_busy  out  1  high while a packet is locked to grant_sel.

Function
REQ-014 Two states: IDLE (no owner) and BUSY (owner locked until its tlast beat is accepted).
REQ-015 In IDLE with any s_axis_sel_tvalid high, the arbiter picks the first valid index searching upward from rr_ptr with wrap-around at INTF_NUM-1, latches it into grant_sel, and enters BUSY on the next edge.
REQ-016 In IDLE, all s_axis_sel_tready bits are 0.
REQ-017 In BUSY, s_axis_sel_tready[grant_sel] = (!m_axis_tvalid || m_axis_tready); all other ready bits are 0.
REQ-018 An accepted input beat (valid && ready on grant_sel) is registered into the output register on the same edge, giving exactly one cycle of latency.
REQ-019 The output register holds tdata/tkeep/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-020 m_axis_tvalid clears after an output handshake unless a new beat is loaded on that same edge.
REQ-021 When the accepted beat has tlast=1, the state returns to IDLE, rr_ptr becomes (grant_sel+1) mod INTF_NUM, and grant_busy falls on that edge.
REQ-022 Minimum packet spacing is one IDLE arbitration cycle; single-beat packets (tlast on the first beat) are legal.
REQ-023 grant_sel is unchanged in IDLE, holding the last owner until a new grant is made.
REQ-024 A non-granted stream that asserts valid waits with ready=0; its data is never sampled.
REQ-025 tkeep is passed through unmodified; the block does not check it.

Reset
REQ-026 Asserting axis_reset, at any time including mid-packet, immediately forces: state IDLE, rr_ptr 0, grant_sel 0, grant_busy 0, m_axis_tvalid 0, m_axis_tdata/tkeep/tlast 0, and all s_axis_sel_tready 0.
REQ-027 A packet interrupted by reset is dropped and not resumed; arbitration restarts from index 0 after reset release.

Structure
REQ-028 No shared package is required; the IDLE/BUSY state encoding is local to the module.
REQ-029 The round-robin next-index search is a natural sub-module, rr_pick (request vector plus pointer in, index and found out); the remaining logic is inline.

Verification
REQ-030 Reset release; stream 2 sends a 3-beat packet 0xA0,0xA1,0xA2 with m_axis_tready=1 -> grant_sel=2 one cycle after the first valid; beats appear on m_axis in order, each one cycle after acceptance; tlast on 0xA2; grant_busy falls.
REQ-031 Streams 0..3 all valid with 1-beat packets continuously -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-032 Stream 1 is mid-packet while stream 0 is valid -> s_axis_sel_tready[0] stays 0 until stream 1's tlast is accepted; the next grant goes to 2 if it is valid, else wraps to 0.
REQ-033 m_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat is lost or duplicated; outputs stay stable while stalled.
REQ-034 axis_reset is pulsed on the 2nd beat of a 4-beat packet from stream 3 -> all outputs are 0 immediately; after release the first valid stream 0 is granted before stream 3.

Source files
------------

// File: rtl/axis_arbiter_pkg.sv
// Shared constants and helpers for the AXI-Stream round-robin arbiter.
// Keeps byte sizing and index wrap arithmetic in one place.
package axis_arbiter_pkg;

    localparam int BYTE_BITS = 8;

    // Next index in a ring of n entries, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/axis_arbiter_rr_pick.sv
// Round-robin search: first set request at or above ptr, else the lowest set
// request overall, which is the same as an upward search wrapping at REQ_NUM-1.
module axis_arbiter_rr_pick #(
    parameter int REQ_NUM   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [REQ_NUM-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    logic [IDX_WIDTH-1:0] idx_hi;
    logic [IDX_WIDTH-1:0] idx_lo;
    logic                 found_hi;
    logic                 found_lo;

    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = IDX_WIDTH'(i);
            end
            if (req[i] && !found_hi && (IDX_WIDTH'(i) >= ptr)) begin
                found_hi = 1'b1;
                idx_hi   = IDX_WIDTH'(i);
            end
        end
    end

    assign idx   = found_hi ? idx_hi : idx_lo;
    assign found = found_lo;

endmodule

// File: rtl/axis_arbiter.sv
// Packet-level round-robin arbiter merging INTF_NUM AXI-Stream inputs into one
// registered output; the owner stays locked until its tlast beat is accepted.
module axis_arbiter
    import axis_arbiter_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SEL_WIDTH       = 2,
    parameter int INTF_NUM        = 4
) (
    input  logic                                        axis_aclk,
    input  logic                                        axis_reset,
    input  logic [INTF_NUM*AXIS_DATA_WIDTH-1:0]         s_axis_sel_tdata,
    input  logic [INTF_NUM*AXIS_DATA_WIDTH/BYTE_BITS-1:0] s_axis_sel_tkeep,
    input  logic [INTF_NUM-1:0]                         s_axis_sel_tvalid,
    input  logic [INTF_NUM-1:0]                         s_axis_sel_tlast,
    output logic [INTF_NUM-1:0]                         s_axis_sel_tready,
    output logic [AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/BYTE_BITS-1:0]        m_axis_tkeep,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    input  logic                                        m_axis_tready,
    output logic [SEL_WIDTH-1:0]                        grant_sel,
    output logic                                        grant_busy
);

    localparam int KEEP_W = AXIS_DATA_WIDTH / BYTE_BITS;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_found;

    logic                       out_room;
    logic                       accept;
    logic [AXIS_DATA_WIDTH-1:0] cur_data;
    logic [KEEP_W-1:0]          cur_keep;
    logic                       cur_valid;
    logic                       cur_last;

    axis_arbiter_rr_pick #(
        .REQ_NUM  (INTF_NUM),
        .IDX_WIDTH(SEL_WIDTH)
    ) u_rr_pick (
        .req  (s_axis_sel_tvalid),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Handshake: a beat moves when valid && ready are both high at a rising
    // edge. The owner sees ready whenever the output register is empty or is
    // being drained on this edge; every other stream sees ready low.
    assign out_room = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        cur_data          = '0;
        cur_keep          = '0;
        cur_valid         = 1'b0;
        cur_last          = 1'b0;
        s_axis_sel_tready = '0;
        for (int i = 0; i < INTF_NUM; i++) begin
            if (grant_sel == SEL_WIDTH'(i)) begin
                cur_data             = s_axis_sel_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                cur_keep             = s_axis_sel_tkeep[i*KEEP_W +: KEEP_W];
                cur_valid            = s_axis_sel_tvalid[i];
                cur_last             = s_axis_sel_tlast[i];
                s_axis_sel_tready[i] = (state == ST_BUSY) && out_room;
            end
        end
    end

    assign accept = (state == ST_BUSY) && out_room && cur_valid;

    // grant_busy is the FSM state made visible: high exactly while in BUSY.
    assign grant_busy = (state == ST_BUSY);

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_sel     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_sel <= pick_idx;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && cur_last) begin
                        state  <= ST_IDLE;
                        rr_ptr <= SEL_WIDTH'(wrap_inc(32'(grant_sel), INTF_NUM));
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A newly loaded beat wins over clearing valid on a same-edge drain.
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= cur_data;
                m_axis_tkeep  <= cur_keep;
                m_axis_tlast  <= cur_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
// Self-checking bench for axis_arbiter: per-stream packet drivers, an output
// scoreboard with an expected-beat queue, and a grant-order log.
module tb_axis_arbiter;

    localparam int W  = 32;
    localparam int SW = 2;
    localparam int N  = 4;
    localparam int KW = W / 8;
    localparam int BW = W + KW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N*W-1:0]  s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [W-1:0]    m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [SW-1:0]   gsel;
    logic            gbusy;

    logic [W-1:0]  td [N];
    logic [KW-1:0] tk [N];
    logic          tv [N];
    logic          tl [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int rdy_mode = 0;
    int pat_base = 0;

    logic [BW-1:0] exp_q[$];
    int grant_q[$];
    int gcyc_q[$];
    int gexp_q[$];
    int lens[3][N];

    axis_arbiter #(
        .AXIS_DATA_WIDTH(W),
        .SEL_WIDTH      (SW),
        .INTF_NUM       (N)
    ) dut (
        .axis_aclk        (clk),
        .axis_reset       (rst),
        .s_axis_sel_tdata (s_tdata),
        .s_axis_sel_tkeep (s_tkeep),
        .s_axis_sel_tvalid(s_tvalid),
        .s_axis_sel_tlast (s_tlast),
        .s_axis_sel_tready(s_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tready    (m_tready),
        .grant_sel        (gsel),
        .grant_busy       (gbusy)
    );

    always_comb begin
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < N; i++) begin
            s_tdata[i*W +: W]   = td[i];
            s_tkeep[i*KW +: KW] = tk[i];
            s_tvalid[i]         = tv[i];
            s_tlast[i]          = tl[i];
        end
    end

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [BW-1:0] beat(input int s, input int b, input int n, input logic [7:0] tag);
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        d = {tag, 8'(s), 8'(b), 8'(n)};
        k = KW'(s + 2 * b + int'(tag));
        return {(b == n - 1), k, d};
    endfunction

    task automatic push_pkt(input int s, input int n, input logic [7:0] tag);
        for (int b = 0; b < n; b++) exp_q.push_back(beat(s, b, n, tag));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input int s, input int n, input logic [7:0] tag);
        int t;
        for (int b = 0; b < n; b++) begin
            {tl[s], tk[s], td[s]} = beat(s, b, n, tag);
            tv[s] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_tready[s] && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!s_tready[s]) check_eq("accept_timeout", 64'(s_tready[s]), 1);
            @(posedge clk);
            #1;
        end
        tv[s] = 1'b0;
        tl[s] = 1'b0;
    endtask

    task automatic stream_rounds(input int s);
        for (int r = 0; r < 3; r++) send_pkt(s, lens[r][s], 8'(8'h50 + r));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_tvalid", 64'(m_tvalid), 0);
        check_eq("rst_tdata", 64'(m_tdata), 0);
        check_eq("rst_tkeep", 64'(m_tkeep), 0);
        check_eq("rst_tlast", 64'(m_tlast), 0);
        check_eq("rst_grant_sel", 64'(gsel), 0);
        check_eq("rst_grant_busy", 64'(gbusy), 0);
        check_eq("rst_tready", 64'(s_tready), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0;
            tl[i] = 1'b0;
            td[i] = '0;
            tk[i] = '0;
        end
        @(posedge clk);
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check_eq("sb_drain", 64'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input bit chk_gap);
        check_eq("grant_count", 64'(grant_q.size()), 64'(gexp_q.size()));
        for (int i = 0; i < gexp_q.size() && i < grant_q.size(); i++)
            check_eq("grant_order", 64'(grant_q[i]), 64'(gexp_q[i]));
        if (chk_gap) begin
            for (int i = 1; i < gcyc_q.size(); i++)
                check_eq("grant_gap", 64'(gcyc_q[i] - gcyc_q[i-1]), 2);
        end
        grant_q.delete();
        gcyc_q.delete();
        gexp_q.delete();
    endtask

    // Downstream ready: 0 = always, 1 = repeating 1,0,0,1, other = random.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (((cycle - pat_base) % 4) == 0) || (((cycle - pat_base) % 4) == 3);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic          prev_stall = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [BW-1:0] prev_out   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_busy  <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(m_tvalid), 1);
                check_eq("stall_hold", 64'({m_tlast, m_tkeep, m_tdata}), 64'(prev_out));
            end
            prev_stall <= m_tvalid && !m_tready;
            prev_out   <= {m_tlast, m_tkeep, m_tdata};
            if (m_tvalid && m_tready) begin
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    check_eq("out_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(exp_q.pop_front()));
            end
            if (gbusy)
                check_eq("ready_other", 64'(s_tready & ~(N'(1) << gsel)), 0);
            else
                check_eq("ready_idle", 64'(s_tready), 0);
            if (gbusy && !prev_busy) begin
                grant_q.push_back(int'(gsel));
                gcyc_q.push_back(cycle);
            end
            prev_busy <= gbusy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // 3-beat packet on stream 2, cycle-exact latency checks.
        exp_q.push_back({1'b0, 4'hF, 32'hA0});
        exp_q.push_back({1'b0, 4'hF, 32'hA1});
        exp_q.push_back({1'b1, 4'hF, 32'hA2});
        td[2] = 32'hA0; tk[2] = 4'hF; tl[2] = 1'b0; tv[2] = 1'b1;
        @(posedge clk); #1;
        check_eq("t1_grant_sel", 64'(gsel), 2);
        check_eq("t1_grant_busy", 64'(gbusy), 1);
        check_eq("t1_no_out_yet", 64'(m_tvalid), 0);
        check_eq("t1_ready", 64'(s_tready), 64'h4);
        @(posedge clk); #1;
        check_eq("t1_lat_valid", 64'(m_tvalid), 1);
        check_eq("t1_beat0", 64'(m_tdata), 64'hA0);
        td[2] = 32'hA1;
        @(posedge clk); #1;
        check_eq("t1_beat1", 64'(m_tdata), 64'hA1);
        td[2] = 32'hA2; tl[2] = 1'b1;
        @(posedge clk); #1;
        check_eq("t1_beat2", 64'(m_tdata), 64'hA2);
        check_eq("t1_tlast", 64'(m_tlast), 1);
        check_eq("t1_busy_fall", 64'(gbusy), 0);
        check_eq("t1_sel_hold", 64'(gsel), 2);
        tv[2] = 1'b0; tl[2] = 1'b0;
        @(posedge clk); #1;
        check_eq("t1_valid_clear", 64'(m_tvalid), 0);
        gexp_q = '{2};
        check_grants(1'b0);

        // All four streams busy with single-beat packets.
        do_reset();
        push_pkt(0, 1, 8'h21); push_pkt(1, 1, 8'h21); push_pkt(2, 1, 8'h21);
        push_pkt(3, 1, 8'h21); push_pkt(0, 1, 8'h22);
        fork
            begin send_pkt(0, 1, 8'h21); send_pkt(0, 1, 8'h22); end
            send_pkt(1, 1, 8'h21);
            send_pkt(2, 1, 8'h21);
            send_pkt(3, 1, 8'h21);
        join
        wait_drain();
        gexp_q = '{0, 1, 2, 3, 0};
        check_grants(1'b1);

        // Stream 1 mid-packet while 0 and 2 wait; next grant goes to 2.
        push_pkt(1, 3, 8'h31); push_pkt(2, 1, 8'h31); push_pkt(0, 1, 8'h31);
        fork
            send_pkt(1, 3, 8'h31);
            begin @(posedge clk); #1; send_pkt(0, 1, 8'h31); end
            begin @(posedge clk); #1; send_pkt(2, 1, 8'h31); end
        join
        wait_drain();
        gexp_q = '{1, 2, 0};
        check_grants(1'b0);

        // Same, but stream 2 idle: the search wraps to 0.
        push_pkt(1, 2, 8'h32); push_pkt(0, 1, 8'h32);
        fork
            send_pkt(1, 2, 8'h32);
            begin @(posedge clk); #1; send_pkt(0, 1, 8'h32); end
        join
        wait_drain();
        gexp_q = '{1, 0};
        check_grants(1'b0);

        // Backpressure 1,0,0,1 across a 4-beat packet.
        rdy_mode = 1;
        pat_base = cycle;
        push_pkt(0, 4, 8'h33);
        send_pkt(0, 4, 8'h33);
        wait_drain();
        rdy_mode = 0;
        gexp_q = '{0};
        check_grants(1'b0);

        // Random lengths and random downstream ready, three full rounds.
        do_reset();
        rdy_mode = 2;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++) begin
                lens[r][s] = $urandom_range(1, 4);
                push_pkt(s, lens[r][s], 8'(8'h50 + r));
                gexp_q.push_back(s);
            end
        fork
            stream_rounds(0);
            stream_rounds(1);
            stream_rounds(2);
            stream_rounds(3);
        join
        wait_drain();
        rdy_mode = 0;
        check_grants(1'b0);

        // Reset on the second beat of a 4-beat packet from stream 3.
        do_reset();
        push_pkt(3, 1, 8'h00);
        exp_q.delete();
        exp_q.push_back(beat(3, 0, 4, 8'h60));
        {tl[3], tk[3], td[3]} = beat(3, 0, 4, 8'h60);
        tv[3] = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_grant_sel", 64'(gsel), 3);
        @(posedge clk); #1;
        {tl[3], tk[3], td[3]} = beat(3, 1, 4, 8'h60);
        @(posedge clk); #1;
        check_eq("t6_pre_reset_valid", 64'(m_tvalid), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        tv[3] = 1'b0;
        tl[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_pkt(0, 1, 8'h61); push_pkt(3, 1, 8'h61);
        fork
            send_pkt(0, 1, 8'h61);
            send_pkt(3, 1, 8'h61);
        join
        wait_drain();
        gexp_q = '{3, 0, 3};
        check_grants(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
